// File: rtl/bytestrip_pkg.sv
// Shared definitions for the 4-lane byte striper (TX) and un-striper (RX).
// Holds the lane word width, lane count, lane-pointer type and the
// lane-valid mask helper used on both sides of the link.
package bytestrip_pkg;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;

  typedef logic [1:0] lane_ptr_t;

  // Mask with the low n lanes set; n ranges 0..LANES.
  function automatic logic [LANES-1:0] mask_for_count(input logic [2:0] n);
    return LANES'((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/bytestriping_tx_if.sv
// Byte-stream in / 4-lane group out bundle for the TX byte striper.
// master: byte source side (drives data/valid/flush, observes lane outputs).
// slave : striper side (consumes the byte stream, drives the lane group).
interface bytestriping_tx_if;
  import bytestrip_pkg::*;

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              flush;
  logic [DATA_W-1:0] data_out0;
  logic [DATA_W-1:0] data_out1;
  logic [DATA_W-1:0] data_out2;
  logic [DATA_W-1:0] data_out3;
  logic [LANES-1:0]  lane_valid;
  logic              valid_out;
  logic              busy;

  modport master (
    output data, valid, flush,
    input  data_out0, data_out1, data_out2, data_out3,
    input  lane_valid, valid_out, busy
  );

  modport slave (
    input  data, valid, flush,
    output data_out0, data_out1, data_out2, data_out3,
    output lane_valid, valid_out, busy
  );

endinterface

// File: rtl/bytestriping_tx.sv
// Purpose: stripes a serial byte stream round-robin onto lanes 0..3 and
//   presents each group on all four lanes at once; flush emits a partial group.
// Latency: the byte completing a group is on data_out3 one clk after sampling.
// Backpressure: none; every valid byte is accepted.
// Ports: clk, reset (sync, active-high); bus (slave) carries data/valid/flush
//   in and data_out0..3, lane_valid, valid_out (1-cycle pulse), busy out.
module bytestriping_tx
  import bytestrip_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  bytestriping_tx_if.slave bus
);

  lane_ptr_t         ptr;
  logic [DATA_W-1:0] slot     [0:2];
  logic [DATA_W-1:0] lane_d   [0:3];
  logic [DATA_W-1:0] out_q    [0:3];
  logic [LANES-1:0]  lane_valid_q;
  logic              valid_out_q;
  logic [2:0]        n;
  logic              emit;

  // n counts the bytes of the group including a byte arriving this cycle.
  // A 4th byte always closes the group, so flush at ptr=3 with valid=1 is
  // naturally the full-group case.
  always_comb begin
    n    = {1'b0, ptr} + {2'b00, bus.valid};
    emit = (bus.valid && (ptr == 2'd3)) || (bus.flush && (n != 3'd0));

    for (int i = 0; i < 3; i++) begin
      lane_d[i] = '0;
      if (lane_ptr_t'(i) < ptr)
        lane_d[i] = slot[i];
      else if ((lane_ptr_t'(i) == ptr) && bus.valid)
        lane_d[i] = bus.data;
    end
    // The last lane never has a slot: it is only ever the arriving byte.
    lane_d[3] = (bus.valid && (ptr == 2'd3)) ? bus.data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= '0;
      lane_valid_q <= '0;
      valid_out_q  <= 1'b0;
      for (int i = 0; i < 3; i++) slot[i]  <= '0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else begin
      valid_out_q <= emit;
      if (emit) begin
        for (int i = 0; i < 4; i++) out_q[i] <= lane_d[i];
        lane_valid_q <= mask_for_count(n);
        ptr          <= '0;
      end else if (bus.valid) begin
        // ptr < 3 here, otherwise the byte would have closed the group.
        slot[ptr] <= bus.data;
        ptr       <= ptr + 2'd1;
      end
    end
  end

  assign bus.data_out0  = out_q[0];
  assign bus.data_out1  = out_q[1];
  assign bus.data_out2  = out_q[2];
  assign bus.data_out3  = out_q[3];
  assign bus.lane_valid = lane_valid_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.busy       = (ptr != '0);

endmodule

// File: tb/tb_bytestriping_tx.sv
module tb_bytestriping_tx;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  bytestriping_tx_if bus ();

  bytestriping_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       f;
    logic [7:0] d;
    logic       evo;
    logic [3:0] elv;
    logic [7:0] e0, e1, e2, e3;
    logic       ebusy;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: pending bytes of the open group plus the last
  // emitted group, which the outputs keep showing between pulses.
  logic [7:0] m_q[$];
  logic [7:0] m_out[4];
  logic [3:0] m_lv;
  logic       m_vo;
  logic       m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic f, input logic [7:0] d);
    @(negedge clk);
    reset     = r;
    bus.valid = v;
    bus.flush = f;
    bus.data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_emit();
    int sz;
    sz = m_q.size();
    for (int i = 0; i < 4; i++) m_out[i] = (i < sz) ? m_q[i] : 8'h00;
    m_lv = 4'((1 << sz) - 1);
    m_vo = 1'b1;
    m_q.delete();
  endtask

  task automatic model_step(input logic r, input logic v, input logic f, input logic [7:0] d);
    m_vo = 1'b0;
    if (r) begin
      m_q.delete();
      for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
      m_lv = 4'h0;
    end else if (v && m_q.size() == 3) begin
      m_q.push_back(d);
      model_emit();
    end else if (f) begin
      if (v) m_q.push_back(d);
      if (m_q.size() > 0) model_emit();
    end else if (v) begin
      m_q.push_back(d);
    end
    m_busy = (m_q.size() != 0);
  endtask

  task automatic chk_all(input string tag, input logic evo, input logic [3:0] elv,
                         input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3, input logic ebusy);
    chk({tag, ".valid_out"},  32'(bus.valid_out),  32'(evo));
    chk({tag, ".lane_valid"}, 32'(bus.lane_valid), 32'(elv));
    chk({tag, ".lanes"}, {bus.data_out0, bus.data_out1, bus.data_out2, bus.data_out3},
        {e0, e1, e2, e3});
    chk({tag, ".busy"}, 32'(bus.busy), 32'(ebusy));
  endtask

  initial begin
    logic r, v, f;
    logic [7:0] d;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    bus.data  = 8'h00;

    // Reset held two cycles with traffic present: everything stays zero.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'hAA);
      chk_all("reset", 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    end

    // Table: full group, hold, flushes (with and without a byte), flush at
    // ptr=0, flush of 3 held bytes, and flush ignored on a completing byte.
    vecs.push_back('{1, 0, 8'h11, 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1});
    vecs.push_back('{1, 0, 8'h22, 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1});
    vecs.push_back('{1, 0, 8'h33, 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1});
    vecs.push_back('{1, 0, 8'h44, 1, 4'hF, 8'h11, 8'h22, 8'h33, 8'h44, 0});
    vecs.push_back('{0, 0, 8'h99, 0, 4'hF, 8'h11, 8'h22, 8'h33, 8'h44, 0});
    vecs.push_back('{1, 0, 8'hA0, 0, 4'hF, 8'h11, 8'h22, 8'h33, 8'h44, 1});
    vecs.push_back('{1, 0, 8'hA1, 0, 4'hF, 8'h11, 8'h22, 8'h33, 8'h44, 1});
    vecs.push_back('{0, 1, 8'h55, 1, 4'h3, 8'hA0, 8'hA1, 8'h00, 8'h00, 0});
    vecs.push_back('{1, 0, 8'hB0, 0, 4'h3, 8'hA0, 8'hA1, 8'h00, 8'h00, 1});
    vecs.push_back('{1, 1, 8'hB1, 1, 4'h3, 8'hB0, 8'hB1, 8'h00, 8'h00, 0});
    vecs.push_back('{0, 1, 8'h66, 0, 4'h3, 8'hB0, 8'hB1, 8'h00, 8'h00, 0});
    vecs.push_back('{1, 1, 8'hE0, 1, 4'h1, 8'hE0, 8'h00, 8'h00, 8'h00, 0});
    vecs.push_back('{1, 0, 8'hF0, 0, 4'h1, 8'hE0, 8'h00, 8'h00, 8'h00, 1});
    vecs.push_back('{1, 0, 8'hF1, 0, 4'h1, 8'hE0, 8'h00, 8'h00, 8'h00, 1});
    vecs.push_back('{1, 0, 8'hF2, 0, 4'h1, 8'hE0, 8'h00, 8'h00, 8'h00, 1});
    vecs.push_back('{0, 1, 8'h77, 1, 4'h7, 8'hF0, 8'hF1, 8'hF2, 8'h00, 0});
    vecs.push_back('{1, 0, 8'h81, 0, 4'h7, 8'hF0, 8'hF1, 8'hF2, 8'h00, 1});
    vecs.push_back('{1, 0, 8'h82, 0, 4'h7, 8'hF0, 8'hF1, 8'hF2, 8'h00, 1});
    vecs.push_back('{1, 0, 8'h83, 0, 4'h7, 8'hF0, 8'hF1, 8'hF2, 8'h00, 1});
    vecs.push_back('{1, 1, 8'h84, 1, 4'hF, 8'h81, 8'h82, 8'h83, 8'h84, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 4'hF, 8'h81, 8'h82, 8'h83, 8'h84, 0});

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].v, vecs[i].f, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].evo, vecs[i].elv,
              vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].ebusy);
    end

    // Streaming with a 3-cycle gap between 02 and 03.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h01);
    chk("gap.vo01", 32'(bus.valid_out), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h02);
    chk("gap.vo02", 32'(bus.valid_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'hEE);
      chk("gap.idle_vo", 32'(bus.valid_out), 32'd0);
      chk("gap.idle_busy", 32'(bus.busy), 32'd1);
    end
    step(1'b0, 1'b1, 1'b0, 8'h03);
    chk("gap.vo03", 32'(bus.valid_out), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h04);
    chk_all("gap.grp1", 1'b1, 4'hF, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    for (int i = 5; i <= 7; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i));
      chk("gap.vo_mid", 32'(bus.valid_out), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 8'h08);
    chk_all("gap.grp2", 1'b1, 4'hF, 8'h05, 8'h06, 8'h07, 8'h08, 1'b0);

    // Reset mid-group: held bytes are dropped, next group is clean.
    step(1'b0, 1'b1, 1'b0, 8'hC0);
    step(1'b0, 1'b1, 1'b0, 8'hC1);
    step(1'b0, 1'b1, 1'b0, 8'hC2);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk_all("midrst", 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'hD0);
    step(1'b0, 1'b1, 1'b0, 8'hD1);
    step(1'b0, 1'b1, 1'b0, 8'hD2);
    chk("midrst.vo", 32'(bus.valid_out), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'hD3);
    chk_all("midrst.grp", 1'b1, 4'hF, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 1'b0);

    // Randomized traffic against the queue-based model.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    model_step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 70);
      f = ($urandom_range(0, 99) < 12);
      d = 8'($urandom);
      step(r, v, f, d);
      model_step(r, v, f, d);
      chk_all("rand", m_vo, m_lv, m_out[0], m_out[1], m_out[2], m_out[3], m_busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bytestriping_tx.md
Name: bytestriping_tx

Overview:
Transmit-side byte striper for the 4-lane link; the counterpart of the bytestriping receiver.
- Accepts a serial byte stream (data/valid) on clk.
- Distributes consecutive bytes round-robin across lanes 0..3 and presents each completed group on all four lanes in the same cycle.
- Supports a flush of a partial group with a per-lane valid mask.
- Sits between the byte source and the lane serializers; the RX un-stripes lanes data_in0..3 back into one stream.

Parameters:
DATA_W, 8, width of one byte/lane word
LANES, 4, number of lanes; fixed at 4 in this revision, and the ports are explicit per lane

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
data  input  DATA_W  input byte
valid  input  1  data is valid this cycle; no backpressure, so every valid byte is accepted
flush  input  1  emit the partial group now
data_out0  output  DATA_W  lane 0 byte (first byte of group)
data_out1  output  DATA_W  lane 1 byte
data_out2  output  DATA_W  lane 2 byte
data_out3  output  DATA_W  lane 3 byte (last byte of group)
lane_valid  output  LANES  per-lane valid mask for the current group, bit i = lane i
valid_out  output  1  one-cycle pulse: group present on data_out0..3
busy  output  1  partial group held (ptr != 0)

Behaviour:
Reset (clk edge with reset=1):
- ptr=0, slot0..2=0, data_out0..3=0, lane_valid=0, valid_out=0, busy=0.
- Reset has priority over valid and flush.
- Reset mid-group discards all held bytes; nothing is emitted.

State:
- 2-bit lane pointer ptr (0..3).
- Holding slots slot0..slot2; the 4th byte never needs a slot.

Per-cycle rules (no reset):
- valid=1, ptr<3, flush=0: slot[ptr]<=data; ptr<=ptr+1; valid_out<=0.
- valid=1, ptr=3:
  - data_out0..2<=slot0..2; data_out3<=data.
  - lane_valid<=4'b1111; valid_out<=1; ptr<=0 (wrap).
  - flush is ignored because the group is already complete.
- flush=1, ptr<3:
  - Let n = ptr + valid, the number of bytes in the group including any byte this cycle.
  - If valid, the byte goes into lane ptr of the emitted group.
  - If n>0: lanes 0..n-1 <= held bytes; lanes n..3 <= 0; lane_valid <= (1<<n)-1; valid_out<=1; ptr<=0.
  - If n=0: no-op; valid_out<=0 and outputs hold.
- valid=0, flush=0: ptr and slots hold; valid_out<=0.

Output timing and holding:
- Latency: the byte that completes a group appears on data_out3 one clk after it is sampled.
- Earlier bytes appear at the same edge as the completing byte.
- data_out0..3 and lane_valid hold their last group between pulses. Consumers qualify with valid_out only.
- busy = (ptr != 0), registered, so it updates with ptr.

Back-to-back operation:
- Continuous valid yields valid_out high every 4th cycle. No bubbles, no byte loss.
- Gaps in valid stretch a group arbitrarily; lane order is preserved.

Decomposition:
- Shared package bytestrip_pkg:
  - DATA_W=8 and LANES=4 constants.
  - Lane-pointer typedef (2-bit).
  - Function mask_for_count(n) returning (1<<n)-1. The RX uses this to validate lanes.
- No sub-module is needed. The pointer/slot logic and the output register stage stay in one module.
- An optional helper, bytestrip_lane_reg (DATA_W register with load and clear), may be instantiated per lane. This is not required.

Test Plan:
1. Reset: hold reset 2 cycles with valid=1, data=8'hAA -> all outputs 0, busy=0, no valid_out.
2. Full group: valid=1 for 4 cycles, data 8'h11,8'h22,8'h33,8'h44 -> one clk after 8'h44: data_out0..3=11,22,33,44, lane_valid=4'hF, valid_out=1 for exactly 1 cycle, ptr=0.
3. Streaming with gaps: 8 bytes 8'h01..8'h08, valid deasserted for 3 cycles between 8'h02 and 8'h03 -> two pulses: lanes 01..04 then 05..08; valid_out is never high during the gap.
4. Flush partial: bytes 8'hA0,8'hA1, then flush=1 with valid=0 -> data_out0=A0, data_out1=A1, data_out2=data_out3=0, lane_valid=4'b0011, valid_out=1, busy=0.
5. Simultaneous flush+valid: after 8'hB0, present 8'hB1 with flush=1 -> lanes B0,B1,0,0, lane_valid=4'b0011. Flush at ptr=0 with valid=0 -> no pulse.
6. Reset mid-group: bytes 8'hC0,8'hC1,8'hC2 then reset -> no emission. Next 4 bytes D0..D3 emit as a clean group with lane_valid=4'hF.
